fpu_issue_ctrl: RTL and testbench

FPU_ISSUE_CTRL -- requirements
Module: fpu_issue_ctrl

---
 rtl/ibex_fp_pkg.sv | 30 +++
 rtl/fpu_issue_ctrl.sv | 206 ++++++++++++++++++++
 tb/tb_fpu_issue_ctrl.sv | 236 +++++++++++++++++++++++
 3 files changed

// File: rtl/ibex_fp_pkg.sv
// Shared FP types: operation encoding, issue-controller state and its default timeout.
package ibex_fp_pkg;

    typedef enum logic [3:0] {
        FPU_NOP       = 4'd0,
        FPU_ADD       = 4'd1,
        FPU_SUB       = 4'd2,
        FPU_MUL       = 4'd3,
        FPU_DIV       = 4'd4,
        FPU_SQRT      = 4'd5,
        FPU_FMADD     = 4'd6,
        FPU_MINMAX    = 4'd7,
        FPU_SGNJ      = 4'd8,
        FPU_CMP       = 4'd9,
        FPU_CLASS     = 4'd10,
        FPU_INT2FLOAT = 4'd11,
        FPU_FLOAT2INT = 4'd12
    } fpu_op_e;

    typedef enum logic [2:0] {
        ISSUE_IDLE  = 3'd0,
        ISSUE_READ  = 3'd1,
        ISSUE_ISSUE = 3'd2,
        ISSUE_WAIT  = 3'd3,
        ISSUE_WB    = 3'd4
    } fpu_issue_state_e;

    localparam int unsigned FPU_TIMEOUT_CYCLES_DEFAULT = 64;

endpackage

// File: rtl/fpu_issue_ctrl.sv
// Issues one decoded FP op at a time: read regfile, hand operands to the FPU,
// wait for the result (with timeout) and write it back to the fp or int regfile.
module fpu_issue_ctrl
    import ibex_fp_pkg::*;
#(
    parameter int unsigned TIMEOUT_CYCLES = FPU_TIMEOUT_CYCLES_DEFAULT
) (
    input  logic        clk_i,
    input  logic        rst_i,

    input  logic        req_valid_i,
    output logic        req_ready_o,
    input  fpu_op_e     req_op_i,
    input  logic [2:0]  req_rm_i,
    input  logic [4:0]  req_rs1_i,
    input  logic [4:0]  req_rs2_i,
    input  logic [4:0]  req_rs3_i,
    input  logic [4:0]  req_rd_i,

    output logic [4:0]  fp_raddr_a_o,
    output logic [4:0]  fp_raddr_b_o,
    output logic [4:0]  fp_raddr_c_o,
    output logic [4:0]  int_raddr_o,
    input  logic [31:0] fp_rdata_a_i,
    input  logic [31:0] fp_rdata_b_i,
    input  logic [31:0] fp_rdata_c_i,
    input  logic [31:0] int_rdata_i,

    output logic        fpu_valid_o,
    input  logic        fpu_ready_i,
    output fpu_op_e     fpu_op_o,
    output logic [2:0]  fpu_rm_o,
    output logic [31:0] fpu_rs1_o,
    output logic [31:0] fpu_rs1_int_o,
    output logic [31:0] fpu_rs2_o,
    output logic [31:0] fpu_rs3_o,
    output logic [4:0]  fpu_rd_o,

    input  logic        fpu_done_i,
    input  logic        fpu_fp_we_i,
    input  logic        fpu_int_we_i,
    input  logic [4:0]  fpu_waddr_i,
    input  logic [31:0] fpu_wdata_i,

    output logic        fp_we_o,
    output logic        int_we_o,
    output logic [4:0]  fp_waddr_o,
    output logic [4:0]  int_waddr_o,
    output logic [31:0] fp_wdata_o,
    output logic [31:0] int_wdata_o,

    output logic        busy_o,
    output logic        timeout_err_o
);

    // Handshakes: a transfer happens at the posedge where valid && ready are both 1;
    // once valid is raised it stays high with a stable payload until that transfer.

    fpu_issue_state_e state_q, state_d;

    fpu_op_e     op_q;
    logic [2:0]  rm_q;
    logic [4:0]  rs1_q, rs2_q, rs3_q, rd_q;
    logic [31:0] opa_q, opb_q, opc_q, opi_q;
    logic        res_fp_we_q, res_int_we_q;
    logic [4:0]  res_waddr_q;
    logic [31:0] res_wdata_q;
    logic [31:0] wait_cnt_q;
    logic        timeout_q;

    logic        req_fire;
    logic        capture_res;
    logic        wait_expire;
    logic        wb_en;

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            state_q <= ISSUE_IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    always_comb begin
        state_d     = state_q;
        req_ready_o = 1'b0;
        busy_o      = 1'b1;
        fpu_valid_o = 1'b0;
        req_fire    = 1'b0;
        capture_res = 1'b0;
        wait_expire = 1'b0;
        wb_en       = 1'b0;
        unique case (state_q)
            ISSUE_IDLE: begin
                req_ready_o = 1'b1;
                busy_o      = 1'b0;
                if (req_valid_i) begin
                    req_fire = 1'b1;
                    state_d  = ISSUE_READ;
                end
            end
            ISSUE_READ: begin
                state_d = (op_q == FPU_NOP) ? ISSUE_IDLE : ISSUE_ISSUE;
            end
            ISSUE_ISSUE: begin
                fpu_valid_o = 1'b1;
                if (fpu_ready_i) begin
                    // A single-cycle FPU may answer in the handshake cycle itself.
                    capture_res = fpu_done_i;
                    state_d     = fpu_done_i ? ISSUE_WB : ISSUE_WAIT;
                end
            end
            ISSUE_WAIT: begin
                if (fpu_done_i) begin
                    capture_res = 1'b1;
                    state_d     = ISSUE_WB;
                end else if (wait_cnt_q == 32'(TIMEOUT_CYCLES - 1)) begin
                    wait_expire = 1'b1;
                    state_d     = ISSUE_IDLE;
                end
            end
            ISSUE_WB: begin
                wb_en   = 1'b1;
                state_d = ISSUE_IDLE;
            end
            default: begin
                state_d = ISSUE_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            op_q         <= FPU_NOP;
            rm_q         <= '0;
            rs1_q        <= '0;
            rs2_q        <= '0;
            rs3_q        <= '0;
            rd_q         <= '0;
            opa_q        <= '0;
            opb_q        <= '0;
            opc_q        <= '0;
            opi_q        <= '0;
            res_fp_we_q  <= 1'b0;
            res_int_we_q <= 1'b0;
            res_waddr_q  <= '0;
            res_wdata_q  <= '0;
            wait_cnt_q   <= '0;
            timeout_q    <= 1'b0;
        end else begin
            if (req_fire) begin
                op_q  <= req_op_i;
                rm_q  <= req_rm_i;
                rs1_q <= req_rs1_i;
                rs2_q <= req_rs2_i;
                rs3_q <= req_rs3_i;
                rd_q  <= req_rd_i;
            end
            if (state_q == ISSUE_READ) begin
                opa_q <= fp_rdata_a_i;
                opb_q <= fp_rdata_b_i;
                opc_q <= fp_rdata_c_i;
                opi_q <= int_rdata_i;
            end
            if (capture_res) begin
                res_fp_we_q  <= fpu_fp_we_i;
                res_int_we_q <= fpu_int_we_i;
                res_waddr_q  <= fpu_waddr_i;
                res_wdata_q  <= fpu_wdata_i;
            end
            // Counter is 0 during the first WAIT cycle and counts WAIT cycles thereafter.
            if (state_q == ISSUE_ISSUE) begin
                wait_cnt_q <= '0;
            end else if (state_q == ISSUE_WAIT) begin
                wait_cnt_q <= wait_cnt_q + 32'd1;
            end
            if (wait_expire) begin
                timeout_q <= 1'b1;
            end
        end
    end

    assign fp_raddr_a_o  = rs1_q;
    assign fp_raddr_b_o  = rs2_q;
    assign fp_raddr_c_o  = rs3_q;
    assign int_raddr_o   = rs1_q;

    assign fpu_op_o      = op_q;
    assign fpu_rm_o      = rm_q;
    assign fpu_rs1_o     = opa_q;
    assign fpu_rs1_int_o = opi_q;
    assign fpu_rs2_o     = opb_q;
    assign fpu_rs3_o     = opc_q;
    assign fpu_rd_o      = rd_q;

    // x0 is hardwired zero in the int file, so its write is dropped; f0 is a real register.
    assign fp_we_o       = wb_en & res_fp_we_q;
    assign int_we_o      = wb_en & res_int_we_q & (res_waddr_q != 5'd0);
    assign fp_waddr_o    = res_waddr_q;
    assign int_waddr_o   = res_waddr_q;
    assign fp_wdata_o    = res_wdata_q;
    assign int_wdata_o   = res_wdata_q;

    assign timeout_err_o = timeout_q;

endmodule

// File: tb/tb_fpu_issue_ctrl.sv
// Bench for fpu_issue_ctrl: mock regfiles and FPU, a write scoreboard and randomized ops.
module tb_fpu_issue_ctrl;
    import ibex_fp_pkg::*;

    localparam int TO = 64;

    logic        clk_i = 1'b0;
    logic        rst_i = 1'b1;
    logic        req_valid_i = 1'b0;
    logic        req_ready_o;
    fpu_op_e     req_op_i = FPU_NOP;
    logic [2:0]  req_rm_i = '0;
    logic [4:0]  req_rs1_i = '0, req_rs2_i = '0, req_rs3_i = '0, req_rd_i = '0;
    logic [4:0]  fp_raddr_a_o, fp_raddr_b_o, fp_raddr_c_o, int_raddr_o;
    logic [31:0] fp_rdata_a_i, fp_rdata_b_i, fp_rdata_c_i, int_rdata_i;
    logic        fpu_valid_o;
    logic        fpu_ready_i = 1'b0;
    fpu_op_e     fpu_op_o;
    logic [2:0]  fpu_rm_o;
    logic [31:0] fpu_rs1_o, fpu_rs1_int_o, fpu_rs2_o, fpu_rs3_o;
    logic [4:0]  fpu_rd_o;
    logic        fpu_done_i = 1'b0, fpu_fp_we_i = 1'b0, fpu_int_we_i = 1'b0;
    logic [4:0]  fpu_waddr_i = '0;
    logic [31:0] fpu_wdata_i = '0;
    logic        fp_we_o, int_we_o;
    logic [4:0]  fp_waddr_o, int_waddr_o;
    logic [31:0] fp_wdata_o, int_wdata_o;
    logic        busy_o, timeout_err_o;

    // Mock regfiles double as the reference model's architectural state.
    logic [31:0] fp_rf [32];
    logic [31:0] int_rf [32];
    logic [38:0] exp_q[$];
    int n_tests = 0;
    int n_fail  = 0;

    fpu_issue_ctrl #(.TIMEOUT_CYCLES(TO)) dut (
        .clk_i(clk_i), .rst_i(rst_i),
        .req_valid_i(req_valid_i), .req_ready_o(req_ready_o),
        .req_op_i(req_op_i), .req_rm_i(req_rm_i),
        .req_rs1_i(req_rs1_i), .req_rs2_i(req_rs2_i), .req_rs3_i(req_rs3_i), .req_rd_i(req_rd_i),
        .fp_raddr_a_o(fp_raddr_a_o), .fp_raddr_b_o(fp_raddr_b_o), .fp_raddr_c_o(fp_raddr_c_o),
        .int_raddr_o(int_raddr_o),
        .fp_rdata_a_i(fp_rdata_a_i), .fp_rdata_b_i(fp_rdata_b_i), .fp_rdata_c_i(fp_rdata_c_i),
        .int_rdata_i(int_rdata_i),
        .fpu_valid_o(fpu_valid_o), .fpu_ready_i(fpu_ready_i),
        .fpu_op_o(fpu_op_o), .fpu_rm_o(fpu_rm_o),
        .fpu_rs1_o(fpu_rs1_o), .fpu_rs1_int_o(fpu_rs1_int_o), .fpu_rs2_o(fpu_rs2_o),
        .fpu_rs3_o(fpu_rs3_o), .fpu_rd_o(fpu_rd_o),
        .fpu_done_i(fpu_done_i), .fpu_fp_we_i(fpu_fp_we_i), .fpu_int_we_i(fpu_int_we_i),
        .fpu_waddr_i(fpu_waddr_i), .fpu_wdata_i(fpu_wdata_i),
        .fp_we_o(fp_we_o), .int_we_o(int_we_o), .fp_waddr_o(fp_waddr_o), .int_waddr_o(int_waddr_o),
        .fp_wdata_o(fp_wdata_o), .int_wdata_o(int_wdata_o),
        .busy_o(busy_o), .timeout_err_o(timeout_err_o)
    );

    always #5 clk_i = ~clk_i;

    assign fp_rdata_a_i = fp_rf[fp_raddr_a_o];
    assign fp_rdata_b_i = fp_rf[fp_raddr_b_o];
    assign fp_rdata_c_i = fp_rf[fp_raddr_c_o];
    assign int_rdata_i  = int_rf[int_raddr_o];

    task automatic check_eq(input string tag, input logic [127:0] obs, input logic [127:0] exp);
        n_tests++;
        if (obs !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic check_idle_zero(input string tag);
        check_eq({tag, "_ready"}, req_ready_o, 1'b1);
        check_eq({tag, "_busy"}, busy_o, 1'b0);
        check_eq({tag, "_valid"}, fpu_valid_o, 1'b0);
        check_eq({tag, "_we"}, {fp_we_o, int_we_o}, 2'b00);
        check_eq({tag, "_timeout"}, timeout_err_o, 1'b0);
        check_eq({tag, "_data"}, {fpu_rs1_o, fpu_rs2_o, fp_wdata_o, int_wdata_o}, 128'd0);
        check_eq({tag, "_addr"}, {fpu_op_o, fp_raddr_a_o, fp_waddr_o, fpu_rd_o}, 19'd0);
    endtask

    function automatic bit is_int_result(input fpu_op_e op);
        return (op == FPU_FLOAT2INT) || (op == FPU_CMP) || (op == FPU_CLASS);
    endfunction

    // mode 0: normal completion, 1: FPU never answers, 2: reset pulsed in WAIT then stale result.
    task automatic run_op(input fpu_op_e op, input logic [4:0] rs1, input logic [4:0] rs2,
                          input logic [4:0] rs3, input logic [4:0] rd, input logic [2:0] rm,
                          input int rdy_dly, input int done_dly, input logic [31:0] res,
                          input int mode);
        logic [31:0] a, b, c, iv;
        logic [38:0] exp_w, obs_w;
        bit int_res, expect_wr;
        int cyc, valid_cyc, hs_cyc, ready_cyc, nwr, wait_cnt, exp_wb;
        bit to_at_ready;
        a = fp_rf[rs1]; b = fp_rf[rs2]; c = fp_rf[rs3]; iv = int_rf[rs1];
        int_res   = is_int_result(op);
        expect_wr = (mode == 0) && (op != FPU_NOP) && !(int_res && rd == 5'd0);
        if (expect_wr) exp_q.push_back({!int_res, int_res, rd, res});

        wait_cnt = 0;
        while (!req_ready_o && wait_cnt < 100) begin
            @(negedge clk_i);
            wait_cnt++;
        end
        check_eq("pre_ready", req_ready_o, 1'b1);
        req_valid_i = 1'b1; req_op_i = op; req_rm_i = rm;
        req_rs1_i = rs1; req_rs2_i = rs2; req_rs3_i = rs3; req_rd_i = rd;
        @(posedge clk_i);
        @(negedge clk_i);
        req_valid_i = 1'b0;
        cyc = 1; valid_cyc = -1; hs_cyc = -1; ready_cyc = -1; nwr = 0; to_at_ready = 1'b0;
        while (cyc < 200) begin
            fpu_ready_i = 1'b0; fpu_done_i = 1'b0; fpu_fp_we_i = 1'b0; fpu_int_we_i = 1'b0;
            fpu_waddr_i = '0; fpu_wdata_i = '0;
            if (fp_we_o || int_we_o) begin
                nwr++;
                obs_w = {fp_we_o, int_we_o, fp_we_o ? fp_waddr_o : int_waddr_o,
                         fp_we_o ? fp_wdata_o : int_wdata_o};
                if (exp_q.size() > 0) begin
                    exp_w = exp_q.pop_front();
                    check_eq("wr_entry", obs_w, exp_w);
                end else begin
                    check_eq("unexpected_wr", obs_w, 39'd0);
                end
                if (mode == 0) begin
                    exp_wb = 3 + rdy_dly + done_dly;
                    check_eq("wb_cycle", cyc, exp_wb);
                end
            end
            if (mode != 2 && req_ready_o) begin
                ready_cyc   = cyc;
                to_at_ready = timeout_err_o;
                break;
            end
            if (mode == 2 && hs_cyc >= 0 && cyc == hs_cyc + 6) begin
                check_idle_zero("rst_wait");
                ready_cyc = cyc;
                break;
            end
            if (fpu_valid_o) begin
                if (valid_cyc < 0) valid_cyc = cyc;
                check_eq("operands", {fpu_rs1_o, fpu_rs2_o, fpu_rs3_o, fpu_rs1_int_o}, {a, b, c, iv});
                check_eq("op_fields", {fpu_op_o, fpu_rm_o, fpu_rd_o}, {op, rm, rd});
                if (cyc - valid_cyc >= rdy_dly) begin
                    fpu_ready_i = 1'b1;
                    hs_cyc = cyc;
                end
            end
            if (mode == 0 && hs_cyc >= 0 && cyc == hs_cyc + done_dly) begin
                fpu_done_i = 1'b1; fpu_fp_we_i = !int_res; fpu_int_we_i = int_res;
                fpu_waddr_i = fpu_rd_o; fpu_wdata_i = res;
            end
            if (mode == 2 && hs_cyc >= 0) begin
                rst_i = (cyc == hs_cyc + 3);
                if (cyc == hs_cyc + 4) begin
                    fpu_done_i = 1'b1; fpu_fp_we_i = 1'b1; fpu_int_we_i = 1'b1;
                    fpu_waddr_i = 5'd5; fpu_wdata_i = res;
                end
            end
            @(posedge clk_i);
            @(negedge clk_i);
            cyc++;
        end
        fpu_ready_i = 1'b0; fpu_done_i = 1'b0; fpu_fp_we_i = 1'b0; fpu_int_we_i = 1'b0;
        rst_i = 1'b0;

        check_eq("op_finished", ready_cyc >= 0, 1'b1);
        if (op == FPU_NOP) begin
            check_eq("nop_no_valid", valid_cyc, -1);
            check_eq("nop_ready_cycle", ready_cyc, 2);
        end else begin
            check_eq("valid_cycle", valid_cyc, 2);
            check_eq("handshake_cycle", hs_cyc, 2 + rdy_dly);
        end
        if (mode == 0 && op != FPU_NOP) check_eq("ready_cycle", ready_cyc, 4 + rdy_dly + done_dly);
        if (mode == 1) begin
            check_eq("timeout_ready_cycle", ready_cyc, 2 + rdy_dly + TO + 1);
            check_eq("timeout_flag", to_at_ready, 1'b1);
        end
        check_eq("write_count", nwr, expect_wr ? 1 : 0);
        if (exp_q.size() != 0) begin
            check_eq("missing_wr", exp_q.size(), 0);
            exp_q.delete();
        end
        if (expect_wr) begin
            if (int_res) int_rf[rd] = res;
            else fp_rf[rd] = res;
        end
    endtask

    initial begin
        fpu_op_e rop;
        for (int i = 0; i < 32; i++) begin
            fp_rf[i]  = $urandom;
            int_rf[i] = (i == 0) ? 32'd0 : $urandom;
        end
        fp_rf[2]  = 32'h4120_0000;
        int_rf[2] = 32'd250;

        repeat (3) @(posedge clk_i);
        @(negedge clk_i);
        check_idle_zero("reset_held");
        rst_i = 1'b0;
        @(negedge clk_i);
        check_idle_zero("reset_released");

        // 10.0 * 10.0 with a same-cycle FPU: minimum latency path.
        run_op(FPU_MUL, 5'd2, 5'd2, 5'd0, 5'd9, 3'd0, 0, 0, 32'h42C8_0000, 0);
        run_op(FPU_INT2FLOAT, 5'd2, 5'd0, 5'd0, 5'd7, 3'd1, 0, 0, 32'h437A_0000, 0);
        run_op(FPU_DIV, 5'd3, 5'd4, 5'd0, 5'd11, 3'd2, 3, 10, 32'h3F80_0000, 0);
        run_op(FPU_FLOAT2INT, 5'd7, 5'd0, 5'd0, 5'd0, 3'd0, 0, 1, 32'hDEAD_BEEF, 0);
        run_op(FPU_NOP, 5'd1, 5'd1, 5'd1, 5'd3, 3'd0, 0, 0, 32'h0, 0);
        run_op(FPU_ADD, 5'd9, 5'd7, 5'd0, 5'd0, 3'd0, 1, 2, 32'h1234_5678, 0);

        for (int i = 0; i < 40; i++) begin
            rop = fpu_op_e'($urandom_range(1, 12));
            if ($urandom_range(0, 7) == 0) rop = FPU_NOP;
            run_op(rop, 5'($urandom_range(0, 31)), 5'($urandom_range(0, 31)),
                   5'($urandom_range(0, 31)), 5'($urandom_range(0, 31)), 3'($urandom_range(0, 7)),
                   $urandom_range(0, 3), $urandom_range(0, 6), $urandom, 0);
        end

        run_op(FPU_SQRT, 5'd4, 5'd0, 5'd0, 5'd12, 3'd0, 1, 0, 32'h0, 1);
        run_op(FPU_SUB, 5'd5, 5'd6, 5'd0, 5'd13, 3'd0, 0, 2, 32'hCAFE_F00D, 0);
        check_eq("timeout_sticky", timeout_err_o, 1'b1);

        run_op(FPU_FMADD, 5'd1, 5'd2, 5'd3, 5'd14, 3'd0, 0, 0, 32'h5555_AAAA, 2);
        run_op(FPU_CMP, 5'd8, 5'd9, 5'd0, 5'd15, 3'd0, 2, 1, 32'h0000_0001, 0);
        check_eq("timeout_after_rst", timeout_err_o, 1'b0);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
